mem_arbiter_nch: RTL and testbench
==================================

# mem_arbiter_nch

Parametrised byte-serial memory controller sitting between N requesting channels (instruction fetch, data cache, and future prefetch/DMA ports) and the single byte-wide synchronous RAM. It arbitrates among channels, splits each 1..MAXB-byte access into byte transfers, reassembles little-endian read data with optional sign extension, and stalls writes while the IO output buffer is full. It supersedes the fixed two-port controller with configurable channel count, access width, arbitration mode and per-request extension mode.

## Interface
- NCH, default 2: number of requesting channels; channel 0 is highest fixed priority.
- ADDR_W, default 32: address width.
- MAXB, default 4: maximum bytes per access, a power of two ≥1; data width is 8·MAXB.
- LEN_W, default clog2(MAXB)+1: length field width.
- ARB_RR, default 0: 0 = fixed priority, 1 = round-robin.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when 0 the block holds all state and drives mem_wr=0.
- io_buffer_full  in  1  IO output buffer full; blocks writes and new grants.
- req_en  in  NCH  per-channel request valid, held until done.
- req_we  in  NCH  1 = store, 0 = load.
- req_sext  in  NCH  load result sign-extended (1) or zero-extended (0).
- req_len  in  NCH·LEN_W  byte count, slice i belongs to channel i.
- req_addr  in  NCH·ADDR_W  start byte address.
- req_wdata  in  NCH·8·MAXB  store data, byte 0 in bits [7:0].
- done  out  NCH  one-cycle completion pulse to the owning channel.
- rdata  out  8·MAXB  load result, valid when done is high; shared by all channels.
- busy  out  1  transaction in progress.
- mem_din  in  8  RAM read data (one-cycle latency).
- mem_dout  out  8  RAM write data.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  1 = write, 0 = read.

## Operation
- States: IDLE, RD, WR.
- IDLE: if io_buffer_full=0, arbitrate over req_en masked by done (a channel whose done is high this cycle is not eligible). Latch addr, len, wdata, sext and the owner index; cnt←0; go to RD or WR. busy=1 from the next cycle.
- Fixed priority: lowest eligible index wins. Round-robin: search starts at (last owner+1) mod NCH; last owner resets to NCH-1.
- Length: req_len 0 or >MAXB is treated as MAXB; every other value is used as given.
- RD, cycle cnt: while cnt<len, mem_a=addr+cnt and mem_wr=0. While cnt≥1, byte cnt-1 is captured from mem_din. At cnt=len the last byte is captured, the result is registered, done[owner]←1, and the state returns to IDLE.
- rdata: bytes beyond len are 0 when sext=0, and copies of bit 7 of the last byte when sext=1.
- WR, cycle cnt with io_buffer_full=0: mem_a=addr+cnt, mem_dout=wdata byte cnt, mem_wr=1, cnt+1. After the byte at cnt=len-1, done[owner]←1 (registered) and the state returns to IDLE.
- WR with io_buffer_full=1: mem_wr=0, cnt holds and nothing is written.
- io_buffer_full does not affect a RD already in progress.
- Address arithmetic wraps modulo 2^ADDR_W.
- When no byte is being issued, mem_a=0, mem_dout=0, mem_wr=0.
- Reset, including mid-transaction: IDLE, cnt=0, done=0, rdata=0, busy=0, mem_a=0, mem_dout=0, mem_wr=0, RR pointer=NCH-1. A partial write is abandoned and the requester must reissue it.

## Timing
- Accept cycle T (IDLE, grant). Load of L bytes: addresses are issued in T+1..T+L and done is high in T+L+2. Store of L bytes with no stalls: writes occur in T+1..T+L and done is high in T+L+1. Each stall cycle adds one cycle.
- done lasts exactly one cycle. rdata holds its value until the next load completes.
- Throughput: a new grant can occur in the done cycle, to a different channel or to the same channel once its req is re-sampled the following cycle.
- rdy=0 freezes every register; RAM data returned during a frozen RD cycle is re-fetched by re-issuing the same address.

## Test plan
- Reset then a 4-byte load by ch1 at 0x100 with RAM bytes 11,22,33,44 → mem_a 0x100..0x103 in T+1..T+4, done[1] in T+6, rdata=0x44332211.
- 1-byte load at 0x20 with byte 0x80, sext=1 → rdata=0xFFFFFF80. Same with sext=0 → rdata=0x00000080.
- 2-byte store of 0xBEEF at 0x40 with io_buffer_full high in T+2 → writes EF@0x40 in T+1 and BE@0x41 in T+3, done in T+4, mem_wr=0 in T+2.
- ch0 and ch1 request simultaneously: with ARB_RR=0, ch0 is served first. With ARB_RR=1 and both held for two transactions, the grants go ch0, ch1, ch0.
- Assert rst during the 3rd byte of a 4-byte store → mem_wr=0 next cycle, no done pulse, busy=0. A fresh load afterwards completes normally.
- Load at 0xFFFFFFFF with len 2 → mem_a FFFFFFFF then 00000000.

Source files
------------

// File: rtl/mem_arbiter_nch.sv
// N-channel arbiter and byte-serial controller for a single byte-wide synchronous RAM.
// Latency: load of L bytes completes L+2 cycles after grant, store L+1 plus stalls; stalls on io_buffer_full (writes/grants) and rdy.
module mem_arbiter_nch #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int MAXB   = 4,
    parameter int LEN_W  = $clog2(MAXB) + 1,
    parameter int ARB_RR = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      io_buffer_full,
    input  logic [NCH-1:0]            req_en,
    input  logic [NCH-1:0]            req_we,
    input  logic [NCH-1:0]            req_sext,
    input  logic [NCH*LEN_W-1:0]      req_len,
    input  logic [NCH*ADDR_W-1:0]     req_addr,
    input  logic [NCH*8*MAXB-1:0]     req_wdata,
    output logic [NCH-1:0]            done,
    output logic [8*MAXB-1:0]         rdata,
    output logic                      busy,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [ADDR_W-1:0]         mem_a,
    output logic                      mem_wr
);

    localparam int DW    = 8 * MAXB;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DW-1:0]      wdata_q;
    logic               sext_q;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_last;
    logic [DW-1:0]      rbuf;

    logic [NCH-1:0]     elig;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic               sel_we;
    logic               sel_sext;
    logic [LEN_W-1:0]   sel_len;
    logic [LEN_W-1:0]   len_eff;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [DW-1:0]      rd_result;
    int                 arb_d;
    int                 arb_best;

    // Each channel gets a search distance; the eligible one closest to the start point wins.
    always_comb begin
        elig      = req_en & ~done;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        sel_we    = 1'b0;
        sel_sext  = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        arb_best  = NCH;
        arb_d     = 0;
        for (int i = 0; i < NCH; i++) begin
            arb_d = (ARB_RR != 0) ? (i + NCH - 1 - int'(rr_last)) % NCH : i;
            if (elig[i] && arb_d < arb_best) begin
                arb_best  = arb_d;
                gnt_vld   = 1'b1;
                gnt_idx   = IDX_W'(i);
                sel_we    = req_we[i];
                sel_sext  = req_sext[i];
                sel_len   = req_len[i*LEN_W +: LEN_W];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
        len_eff = (sel_len == '0 || sel_len > LEN_W'(MAXB)) ? LEN_W'(MAXB) : sel_len;
    end

    // Final byte comes straight from mem_din in the completion cycle.
    always_comb begin
        rd_result = rbuf;
        for (int b = 0; b < MAXB; b++) begin
            if (b + 1 == int'(len_q)) begin
                rd_result[b*8 +: 8] = mem_din;
            end else if (b >= int'(len_q)) begin
                rd_result[b*8 +: 8] = sext_q ? {8{mem_din[7]}} : 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sext_q  <= 1'b0;
            owner   <= '0;
            rr_last <= IDX_W'(NCH - 1);
            rbuf    <= '0;
            rdata   <= '0;
            done    <= '0;
        end else if (rdy) begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (!io_buffer_full && gnt_vld) begin
                        addr_q  <= sel_addr;
                        len_q   <= len_eff;
                        wdata_q <= sel_wdata;
                        sext_q  <= sel_sext;
                        owner   <= gnt_idx;
                        rr_last <= gnt_idx;
                        cnt     <= '0;
                        state   <= sel_we ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    for (int b = 0; b < MAXB; b++) begin
                        if (int'(cnt) == b + 1) rbuf[b*8 +: 8] <= mem_din;
                    end
                    if (cnt == len_q) begin
                        rdata <= rd_result;
                        for (int i = 0; i < NCH; i++) begin
                            if (int'(owner) == i) done[i] <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WR: begin
                    if (!io_buffer_full) begin
                        if (cnt == len_q - LEN_W'(1)) begin
                            for (int i = 0; i < NCH; i++) begin
                                if (int'(owner) == i) done[i] <= 1'b1;
                            end
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // While frozen in RD, the address of the byte still owed is re-driven so it is valid on resume.
    always_comb begin
        mem_a    = '0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        case (state)
            S_RD: begin
                if (rdy) begin
                    if (cnt < len_q) mem_a = addr_q + ADDR_W'(cnt);
                end else if (cnt != '0) begin
                    mem_a = addr_q + ADDR_W'(cnt) - ADDR_W'(1);
                end
            end
            S_WR: begin
                if (rdy && !io_buffer_full) begin
                    mem_a  = addr_q + ADDR_W'(cnt);
                    mem_wr = 1'b1;
                    for (int b = 0; b < MAXB; b++) begin
                        if (int'(cnt) == b) mem_dout = wdata_q[b*8 +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch: fixed-priority 2-channel instance plus a 3-channel round-robin instance.
module tb_mem_arbiter_nch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, io_full;
    logic [1:0]  req_en, req_we, req_sext;
    logic [5:0]  req_len;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [2:0]  rr_req_en;
    logic [8:0]  rr_req_len;
    logic [95:0] rr_req_addr;
    logic [2:0]  rr_done;
    logic [31:0] rr_rdata;
    logic        rr_busy;
    logic [7:0]  rr_mem_din, rr_mem_dout;
    logic [31:0] rr_mem_a;
    logic        rr_mem_wr;

    int checks = 0;
    int failures = 0;

    mem_arbiter_nch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_full),
        .req_en(req_en), .req_we(req_we), .req_sext(req_sext), .req_len(req_len),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
        .busy(busy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_arbiter_nch #(.NCH(3), .ARB_RR(1)) dut_rr (
        .clk(clk), .rst(rst), .rdy(1'b1), .io_buffer_full(1'b0),
        .req_en(rr_req_en), .req_we(3'b000), .req_sext(3'b000), .req_len(rr_req_len),
        .req_addr(rr_req_addr), .req_wdata(96'h0), .done(rr_done), .rdata(rr_rdata),
        .busy(rr_busy), .mem_din(rr_mem_din), .mem_dout(rr_mem_dout), .mem_a(rr_mem_a), .mem_wr(rr_mem_wr)
    );

    // RAM model: preset contents from rom(), overridden by anything written.
    logic [7:0] wmem [0:4095];
    logic       wvld [0:4095];
    logic       ram_clr;

    function automatic logic [7:0] rom(input logic [11:0] a);
        case (a)
            12'h100: return 8'h11;
            12'h101: return 8'h22;
            12'h102: return 8'h33;
            12'h103: return 8'h44;
            12'h020: return 8'h80;
            12'h021: return 8'h9A;
            12'hFFF: return 8'h5A;
            12'h000: return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [11:0] a);
        if (wvld[a] === 1'b1) return wmem[a];
        return rom(a);
    endfunction

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 4096; i++) wvld[i] <= 1'b0;
        end else if (mem_wr) begin
            wmem[mem_a[11:0]] <= mem_dout;
            wvld[mem_a[11:0]] <= 1'b1;
        end
        mem_din <= ram_rd(mem_a[11:0]);
    end

    always @(posedge clk) rr_mem_din <= rr_mem_a[7:0];

    task automatic set_req(input int ch, input logic we, input logic sx, input logic [2:0] len,
                           input logic [31:0] a, input logic [31:0] wd);
        req_we[ch]             = we;
        req_sext[ch]           = sx;
        req_len[ch*3 +: 3]     = len;
        req_addr[ch*32 +: 32]  = a;
        req_wdata[ch*32 +: 32] = wd;
    endtask

    // Issues one load and reports latency (cycles after the accept cycle), result and first two addresses.
    task automatic run_load(input int ch, input logic [31:0] addr, input logic [2:0] len, input logic sx,
                            output int lat, output logic [31:0] data, output logic [31:0] a1, output logic [31:0] a2);
        @(posedge clk); #1;
        set_req(ch, 1'b0, sx, len, addr, 32'h0);
        req_en[ch] = 1'b1;
        lat = -1; data = 32'h0; a1 = 32'h0; a2 = 32'h0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) a1 = mem_a;
            if (k == 2) a2 = mem_a;
            if (done[ch]) begin
                lat = k; data = rdata;
                break;
            end
        end
        req_en[ch] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done: got %b expected 00", done); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (busy !== 1'b0 || rr_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b%b expected 00", busy, rr_busy); end
        checks++; if ({mem_a, mem_dout, mem_wr} !== 41'h0) begin failures++; $display("FAIL reset_mem: got a=%h d=%h wr=%b expected zeros", mem_a, mem_dout, mem_wr); end
        @(posedge clk); #1;
        rst = 1'b0; ram_clr = 1'b0;
    endtask

    task automatic test_load_basic();
        int lat; logic [31:0] d, a1, a2;
        run_load(1, 32'h100, 3'd4, 1'b0, lat, d, a1, a2);
        checks++; if (lat !== 6) begin failures++; $display("FAIL load4_latency: got %0d expected 6", lat); end
        checks++; if (d !== 32'h44332211) begin failures++; $display("FAIL load4_rdata: got %h expected 44332211", d); end
        checks++; if (a1 !== 32'h100 || a2 !== 32'h101) begin failures++; $display("FAIL load4_addr: got %h,%h expected 100,101", a1, a2); end
        @(negedge clk);
        checks++; if (done !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got done=%b busy=%b expected 00 0", done, busy); end
    endtask

    task automatic test_store_stall();
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0000BEEF);
        req_en[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            io_full = (k == 2);
            @(negedge clk);
            if (k == 1) begin
                checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h40, 8'hEF}) begin failures++; $display("FAIL store_byte0: got wr=%b a=%h d=%h expected 1 40 EF", mem_wr, mem_a, mem_dout); end
            end else if (k == 2) begin
                checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL store_stall: got wr=%b expected 0", mem_wr); end
            end else if (k == 3) begin
                checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h41, 8'hBE}) begin failures++; $display("FAIL store_byte1: got wr=%b a=%h d=%h expected 1 41 BE", mem_wr, mem_a, mem_dout); end
            end else if (k == 4) begin
                checks++; if (done !== 2'b01) begin failures++; $display("FAIL store_done: got %b expected 01", done); end
                req_en[0] = 1'b0;
            end else begin
                checks++; if (done !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL store_after: got done=%b busy=%b expected 00 0", done, busy); end
            end
        end
        checks++; if (ram_rd(12'h040) !== 8'hEF || ram_rd(12'h041) !== 8'hBE) begin failures++; $display("FAIL store_ram: got %h%h expected BEEF", ram_rd(12'h041), ram_rd(12'h040)); end
        checks++; if (rdata !== 32'h44332211) begin failures++; $display("FAIL rdata_hold: got %h expected 44332211", rdata); end
    endtask

    task automatic test_sext();
        int lat; logic [31:0] d, a1, a2;
        run_load(0, 32'h20, 3'd1, 1'b1, lat, d, a1, a2);
        checks++; if (lat !== 3 || d !== 32'hFFFFFF80) begin failures++; $display("FAIL sext1: got lat=%0d %h expected 3 FFFFFF80", lat, d); end
        run_load(0, 32'h20, 3'd1, 1'b0, lat, d, a1, a2);
        checks++; if (lat !== 3 || d !== 32'h00000080) begin failures++; $display("FAIL zext1: got lat=%0d %h expected 3 00000080", lat, d); end
        run_load(0, 32'h20, 3'd2, 1'b1, lat, d, a1, a2);
        checks++; if (lat !== 4 || d !== 32'hFFFF9A80) begin failures++; $display("FAIL sext2: got lat=%0d %h expected 4 FFFF9A80", lat, d); end
    endtask

    task automatic test_len_clamp();
        int lat; logic [31:0] d, a1, a2;
        run_load(1, 32'h100, 3'd0, 1'b0, lat, d, a1, a2);
        checks++; if (lat !== 6 || d !== 32'h44332211) begin failures++; $display("FAIL len0: got lat=%0d %h expected 6 44332211", lat, d); end
        run_load(1, 32'h100, 3'd5, 1'b0, lat, d, a1, a2);
        checks++; if (lat !== 6 || d !== 32'h44332211) begin failures++; $display("FAIL len5: got lat=%0d %h expected 6 44332211", lat, d); end
        run_load(0, 32'h101, 3'd3, 1'b1, lat, d, a1, a2);
        checks++; if (lat !== 5 || d !== 32'h00443322) begin failures++; $display("FAIL len3: got lat=%0d %h expected 5 00443322", lat, d); end
    endtask

    task automatic test_fixed_prio();
        logic [1:0] dn [2]; int kk [2]; logic [31:0] rd [2]; int n;
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 3'd1, 32'h20, 32'h0);
        set_req(1, 1'b0, 1'b0, 3'd1, 32'h100, 32'h0);
        req_en = 2'b11;
        n = 0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                dn[n] = done; kk[n] = k; rd[n] = rdata;
                req_en = req_en & ~done;
                n++;
                if (n == 2) break;
            end
        end
        req_en = 2'b00;
        checks++; if (n !== 2) begin failures++; $display("FAIL prio_count: got %0d expected 2", n); end
        else begin
            checks++; if (dn[0] !== 2'b01 || kk[0] !== 3 || rd[0] !== 32'h80) begin failures++; $display("FAIL prio_first: got %b@%0d %h expected 01@3 80", dn[0], kk[0], rd[0]); end
            checks++; if (dn[1] !== 2'b10 || kk[1] !== 6 || rd[1] !== 32'h11) begin failures++; $display("FAIL prio_second: got %b@%0d %h expected 10@6 11", dn[1], kk[1], rd[1]); end
        end
    endtask

    task automatic test_io_block();
        int lat; logic [31:0] d;
        @(posedge clk); #1;
        io_full = 1'b1;
        set_req(0, 1'b0, 1'b0, 3'd1, 32'h20, 32'h0);
        req_en[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL io_block_grant: got busy=%b expected 0", busy); end
        @(posedge clk); #1;
        io_full = 1'b0;
        lat = -1; d = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            io_full = 1'b1;
            @(negedge clk);
            if (done[0]) begin lat = k; d = rdata; break; end
        end
        io_full = 1'b0; req_en[0] = 1'b0;
        checks++; if (lat !== 3 || d !== 32'h80) begin failures++; $display("FAIL io_rd_unaffected: got lat=%0d %h expected 3 80", lat, d); end
    endtask

    task automatic test_rdy_freeze();
        int lat; logic [31:0] d;
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 3'd2, 32'h20, 32'h0);
        req_en[1] = 1'b1;
        lat = -1; d = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            rdy = (k != 2);
            @(negedge clk);
            if (done[1]) begin lat = k; d = rdata; break; end
        end
        rdy = 1'b1; req_en[1] = 1'b0;
        checks++; if (lat !== 5 || d !== 32'h00009A80) begin failures++; $display("FAIL rdy_freeze: got lat=%0d %h expected 5 00009A80", lat, d); end
    endtask

    task automatic test_reset_mid_store();
        int n, lat; logic [31:0] d, a1, a2;
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 3'd4, 32'h200, 32'h0A0B0C0D);
        req_en[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) rst = 1'b1;
            @(negedge clk);
        end
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h202, 8'h0B}) begin failures++; $display("FAIL rst_third_byte: got wr=%b a=%h d=%h expected 1 202 0B", mem_wr, mem_a, mem_dout); end
        @(posedge clk); #1;
        rst = 1'b0; req_en[1] = 1'b0;
        @(negedge clk);
        checks++; if ({mem_wr, busy, done} !== 4'b0000 || rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_state: got wr=%b busy=%b done=%b rdata=%h expected 0 0 00 0", mem_wr, busy, done, rdata); end
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (done != 2'b00 || mem_wr) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL rst_no_done: got %0d activity cycles expected 0", n); end
        run_load(0, 32'h100, 3'd4, 1'b0, lat, d, a1, a2);
        checks++; if (lat !== 6 || d !== 32'h44332211) begin failures++; $display("FAIL rst_fresh_load: got lat=%0d %h expected 6 44332211", lat, d); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] d, a1, a2;
        run_load(0, 32'hFFFFFFFF, 3'd2, 1'b0, lat, d, a1, a2);
        checks++; if (a1 !== 32'hFFFFFFFF || a2 !== 32'h00000000) begin failures++; $display("FAIL wrap_addr: got %h,%h expected FFFFFFFF,00000000", a1, a2); end
        checks++; if (lat !== 4 || d !== 32'h0000C35A) begin failures++; $display("FAIL wrap_rdata: got lat=%0d %h expected 4 0000C35A", lat, d); end
    endtask

    task automatic test_round_robin();
        int seq [4]; logic [31:0] rd [4]; int n;
        @(posedge clk); #1;
        rr_req_len  = {3'd1, 3'd1, 3'd1};
        rr_req_addr = {32'h77, 32'h55, 32'h33};
        rr_req_en   = 3'b111;
        n = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (rr_done != 3'b000) begin
                seq[n] = (rr_done == 3'b001) ? 0 : (rr_done == 3'b010) ? 1 : (rr_done == 3'b100) ? 2 : -1;
                rd[n] = rr_rdata;
                n++;
                if (n == 4) break;
            end
        end
        rr_req_en = 3'b000;
        checks++; if (n !== 4) begin failures++; $display("FAIL rr_count: got %0d expected 4", n); end
        else begin
            checks++; if (seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 2 || seq[3] !== 0) begin failures++; $display("FAIL rr_order: got %0d,%0d,%0d,%0d expected 0,1,2,0", seq[0], seq[1], seq[2], seq[3]); end
            checks++; if (rd[1] !== 32'h55 || rd[2] !== 32'h77) begin failures++; $display("FAIL rr_rdata: got %h,%h expected 55,77", rd[1], rd[2]); end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; io_full = 1'b0; ram_clr = 1'b1;
        req_en = '0; req_we = '0; req_sext = '0; req_len = '0; req_addr = '0; req_wdata = '0;
        rr_req_en = '0; rr_req_len = '0; rr_req_addr = '0;
        test_reset();
        test_load_basic();
        test_store_stall();
        test_sext();
        test_len_clamp();
        test_fixed_prio();
        test_io_block();
        test_rdy_freeze();
        test_reset_mid_store();
        test_wrap();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
